// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared processor-to-memory bus. The data cache (D) normally
// wins. A starvation counter forces the instruction cache (I) through after
// STARVE_LIMIT denials. A tag ownership table routes returning load data back
// to the port that issued the load.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_OUT_I    = 8,
  parameter int MAX_OUT_D    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  ic_command,
  input  logic [63:0] ic_addr,
  output logic [3:0]  ic_response,
  output logic [3:0]  ic_tag,
  output logic [63:0] ic_data,
  input  logic [1:0]  dc_command,
  input  logic [63:0] dc_addr,
  input  logic [63:0] dc_wr_data,
  output logic [3:0]  dc_response,
  output logic [3:0]  dc_tag,
  output logic [63:0] dc_data,
  output logic [1:0]  mem_command,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_data,
  input  logic [3:0]  mem_response,
  input  logic [3:0]  mem_tag,
  input  logic [63:0] mem_data_in,
  output logic [3:0]  ic_outstanding,
  output logic [3:0]  dc_outstanding
);

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [15:0]   pend;   // bit 0 is never set: tag 0 means "none"
  logic [15:0]   owner;  // 0 = I, 1 = D
  logic [3:0]    ic_out_cnt, dc_out_cnt;

  logic i_elig, d_elig, grant_i, grant_d, accepted, acc_load;
  logic ret_valid, ret_to_i, ret_to_d;

  // Eligibility, grant selection and return decode.
  always_comb begin
    i_elig = (ic_command == BUS_LOAD) && (ic_out_cnt < 4'(MAX_OUT_I));
    d_elig = (dc_command == BUS_STORE) ||
             ((dc_command == BUS_LOAD) && (dc_out_cnt < 4'(MAX_OUT_D)));
    // While reset is held, no grant is issued, so every bus output is idle.
    grant_i = reset && i_elig && ((starve_cnt == SW'(STARVE_LIMIT)) || !d_elig);
    grant_d = reset && d_elig && !grant_i;
    accepted = (grant_i || grant_d) && (mem_response != 4'd0);
    acc_load = accepted && (grant_i || (dc_command == BUS_LOAD));
    ret_valid = reset && (mem_tag != 4'd0) && pend[mem_tag];
    ret_to_i  = ret_valid && !owner[mem_tag];
    ret_to_d  = ret_valid &&  owner[mem_tag];
  end

  // Bus multiplexing and response/tag routing.
  always_comb begin
    mem_command = BUS_NONE;
    mem_addr    = 64'd0;
    mem_data    = 64'd0;
    if (grant_i) begin
      mem_command = BUS_LOAD;
      mem_addr    = ic_addr;
    end else if (grant_d) begin
      mem_command = dc_command;
      mem_addr    = dc_addr;
      mem_data    = dc_wr_data;
    end
    ic_response    = grant_i ? mem_response : 4'd0;
    dc_response    = grant_d ? mem_response : 4'd0;
    ic_tag         = ret_to_i ? mem_tag : 4'd0;
    dc_tag         = ret_to_d ? mem_tag : 4'd0;
    ic_data        = mem_data_in;
    dc_data        = mem_data_in;
    ic_outstanding = ic_out_cnt;
    dc_outstanding = dc_out_cnt;
  end

  // Next starvation count for port I.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would infer a latch.
    starve_nxt = starve_cnt;
    if (ic_command != BUS_LOAD) begin
      starve_nxt = '0;
    end else if (grant_i) begin
      if (accepted) starve_nxt = '0;
    end else if (i_elig && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_nxt = starve_cnt + SW'(1);
    end
  end

  // Ownership table, pending bits, outstanding counters and starvation state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the tag table is reset as well, because a reset must discard
      // every in-flight load; tags that return later have to be ignored.
      pend       <= '0;
      owner      <= '0;
      ic_out_cnt <= '0;
      dc_out_cnt <= '0;
      starve_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments; the later set overrides the earlier
      // clear when a tag returns and is re-issued in the same cycle.
      if (ret_valid) pend[mem_tag] <= 1'b0;
      if (acc_load) begin
        pend[mem_response]  <= 1'b1;
        owner[mem_response] <= grant_d;
      end
      ic_out_cnt <= ic_out_cnt + 4'(acc_load && grant_i) - 4'(ret_to_i);
      dc_out_cnt <= dc_out_cnt + 4'(acc_load && grant_d) - 4'(ret_to_d);
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle with a
// behavioural model built on plain arrays and integers.
module tb_mem_bus_arbiter;

  localparam int SL = 4;
  localparam int MI = 8;
  localparam int MD = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ic_command, dc_command, mem_command;
  logic [63:0] ic_addr, dc_addr, dc_wr_data, mem_addr, mem_data, mem_data_in;
  logic [63:0] ic_data, dc_data;
  logic [3:0]  ic_response, ic_tag, dc_response, dc_tag;
  logic [3:0]  mem_response, mem_tag, ic_outstanding, dc_outstanding;

  mem_bus_arbiter #(.STARVE_LIMIT(SL), .MAX_OUT_I(MI), .MAX_OUT_D(MD)) dut (
    .clock(clock), .reset(reset),
    .ic_command(ic_command), .ic_addr(ic_addr), .ic_response(ic_response),
    .ic_tag(ic_tag), .ic_data(ic_data),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_wr_data(dc_wr_data),
    .dc_response(dc_response), .dc_tag(dc_tag), .dc_data(dc_data),
    .mem_command(mem_command), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_response(mem_response), .mem_tag(mem_tag), .mem_data_in(mem_data_in),
    .ic_outstanding(ic_outstanding), .dc_outstanding(dc_outstanding)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Behavioural model: which port owns each pending tag, per-port load
  // counts, and how many consecutive cycles I has been passed over.
  bit m_pend[16];
  bit m_owner_d[16];
  int m_ic_cnt, m_dc_cnt, m_starve;

  // Compare process: outputs are stable at the falling edge; the model then
  // advances to the state the DUT will hold after the next rising edge.
  always @(negedge clock) begin
    int who;   // 0 none, 1 I, 2 D
    bit i_ok, d_ok, ret, acc, is_load;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_data;
    logic [3:0]  e_ir, e_dr, e_it, e_dt;
    if (!reset) begin
      foreach (m_pend[t]) begin m_pend[t] = 0; m_owner_d[t] = 0; end
      m_ic_cnt = 0; m_dc_cnt = 0; m_starve = 0;
      check("rst_mem_command", mem_command, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_data", mem_data, 0);
      check("rst_responses", {ic_response, dc_response}, 0);
      check("rst_tags", {ic_tag, dc_tag}, 0);
      check("rst_counts", {ic_outstanding, dc_outstanding}, 0);
    end else begin
      i_ok = (ic_command == 2'd1) && (m_ic_cnt < MI);
      d_ok = (dc_command == 2'd2) || ((dc_command == 2'd1) && (m_dc_cnt < MD));
      if (i_ok && m_starve == SL) who = 1;
      else if (d_ok)              who = 2;
      else if (i_ok)              who = 1;
      else                        who = 0;
      e_cmd  = (who == 1) ? 2'd1 : (who == 2) ? dc_command : 2'd0;
      e_addr = (who == 1) ? ic_addr : (who == 2) ? dc_addr : 64'd0;
      e_data = (who == 2) ? dc_wr_data : 64'd0;
      e_ir   = (who == 1) ? mem_response : 4'd0;
      e_dr   = (who == 2) ? mem_response : 4'd0;
      ret    = (mem_tag != 0) && m_pend[mem_tag];
      e_it   = (ret && !m_owner_d[mem_tag]) ? mem_tag : 4'd0;
      e_dt   = (ret &&  m_owner_d[mem_tag]) ? mem_tag : 4'd0;
      check("mem_command", mem_command, e_cmd);
      check("mem_addr", mem_addr, e_addr);
      check("mem_data", mem_data, e_data);
      check("ic_response", ic_response, e_ir);
      check("dc_response", dc_response, e_dr);
      check("ic_tag", ic_tag, e_it);
      check("dc_tag", dc_tag, e_dt);
      check("data_passthru", {ic_data ^ mem_data_in, dc_data ^ mem_data_in}, 0);
      check("ic_outstanding", ic_outstanding, m_ic_cnt);
      check("dc_outstanding", dc_outstanding, m_dc_cnt);
      check("starve_cnt", dut.starve_cnt, m_starve);
      // Advance: return uses the old owner, then a new acceptance overrides.
      acc     = (who != 0) && (mem_response != 0);
      is_load = (e_cmd == 2'd1);
      if (ret) begin
        m_pend[mem_tag] = 0;
        if (m_owner_d[mem_tag]) m_dc_cnt--; else m_ic_cnt--;
      end
      if (acc && is_load) begin
        m_pend[mem_response]    = 1;
        m_owner_d[mem_response] = (who == 2);
        if (who == 2) m_dc_cnt++; else m_ic_cnt++;
      end
      if (ic_command != 2'd1)   m_starve = 0;
      else if (who == 1)        m_starve = acc ? 0 : m_starve;
      else if (i_ok)            m_starve = (m_starve < SL) ? m_starve + 1 : SL;
    end
  end

  task automatic to_neg();  @(negedge clock); #1; endtask
  task automatic to_next(); @(posedge clock); #1; endtask

  task automatic idle();
    ic_command = 0; ic_addr = 0; dc_command = 0; dc_addr = 0; dc_wr_data = 0;
    mem_response = 0; mem_tag = 0;
  endtask

  function automatic int pick_free();
    for (int k = 0; k < 20; k++) begin
      int t = $urandom_range(15, 1);
      if (!m_pend[t]) return t;
    end
    return 0;
  endfunction

  function automatic int pick_pending();
    for (int k = 0; k < 20; k++) begin
      int t = $urandom_range(15, 1);
      if (m_pend[t]) return t;
    end
    return 0;
  endfunction

  initial begin
    reset = 1'b0; idle(); mem_data_in = 64'hDEAD_BEEF_0000_0001;
    // Reset for two cycles, then idle.
    to_next(); to_next();
    reset = 1'b1;
    to_neg();
    check("idle_cmd", mem_command, 0);
    check("idle_resp", {ic_response, dc_response}, 0);
    check("idle_cnt", {ic_outstanding, dc_outstanding}, 0);
    check("idle_starve", dut.starve_cnt, 0);
    to_next();

    // D beats I; load tag 3 returns to D.
    dc_command = 1; dc_addr = 64'h100; ic_command = 1; ic_addr = 64'h200; mem_response = 3;
    to_neg();
    check("d_prio_cmd", mem_command, 1);
    check("d_prio_addr", mem_addr, 64'h100);
    check("d_prio_dresp", dc_response, 3);
    check("d_prio_iresp", ic_response, 0);
    to_next(); idle();
    check("d_out_1", dc_outstanding, 1);
    mem_tag = 3; mem_data_in = 64'h1234_5678_9ABC_DEF0;
    to_neg();
    check("d_ret_dtag", dc_tag, 3);
    check("d_ret_itag", ic_tag, 0);
    check("d_ret_data", dc_data, 64'h1234_5678_9ABC_DEF0);
    to_next(); mem_tag = 0;
    check("d_out_0", dc_outstanding, 0);

    // Starvation: D stores continuously, I forced through on the 5th cycle.
    dc_command = 2; dc_addr = 64'h500; dc_wr_data = 64'hABCD; ic_command = 1; ic_addr = 64'h40;
    mem_response = 2;
    for (int k = 1; k <= 5; k++) begin
      to_neg();
      if (k < 5) begin
        check("starve_d_grant", dc_response, 2);
        check("starve_i_wait", ic_response, 0);
      end else begin
        check("starve_i_grant", ic_response, 2);
        check("starve_i_addr", mem_addr, 64'h40);
        check("starve_d_wait", dc_response, 0);
      end
      to_next();
    end
    check("starve_cleared", dut.starve_cnt, 0);
    idle(); mem_tag = 2;
    to_neg(); check("starve_ret_itag", ic_tag, 2);
    to_next(); idle();

    // Outstanding cap on I.
    for (int k = 0; k < 8; k++) begin
      ic_command = 1; ic_addr = 64'h1000 + 64'(k); mem_response = 4'(k + 1);
      to_neg(); to_next();
    end
    check("cap_i_8", ic_outstanding, 8);
    ic_addr = 64'h2000; mem_response = 9; mem_tag = 1;
    to_neg();
    check("cap_blocked_cmd", mem_command, 0);
    check("cap_blocked_resp", ic_response, 0);
    check("cap_ret_tag", ic_tag, 1);
    to_next(); mem_tag = 0;
    check("cap_i_7", ic_outstanding, 7);
    to_neg();
    check("cap_reissue_cmd", mem_command, 1);
    check("cap_reissue_resp", ic_response, 9);
    to_next(); idle();
    check("cap_i_8b", ic_outstanding, 8);

    // Same-tag return and re-issue: tag 5 leaves I, goes to D.
    dc_command = 1; dc_addr = 64'h300; mem_response = 5; mem_tag = 5;
    to_neg();
    check("swap_itag", ic_tag, 5);
    check("swap_dtag", dc_tag, 0);
    check("swap_dresp", dc_response, 5);
    to_next(); idle(); mem_tag = 5;
    to_neg();
    check("swap_dtag2", dc_tag, 5);
    check("swap_itag2", ic_tag, 0);
    to_next(); idle();
    check("swap_counts", {ic_outstanding, dc_outstanding}, {4'd7, 4'd0});

    // Mid-operation reset discards pending tags.
    reset = 1'b0;
    to_next();
    check("midrst_cnt", ic_outstanding, 0);
    reset = 1'b1; mem_tag = 3;
    to_neg();
    check("midrst_stale_tag", {ic_tag, dc_tag}, 0);
    to_next(); idle();

    // Accepted STORE records nothing.
    dc_command = 2; dc_addr = 64'h700; dc_wr_data = 64'h1234; mem_response = 7;
    to_neg();
    check("store_data", mem_data, 64'h1234);
    check("store_resp", dc_response, 7);
    to_next(); idle(); mem_tag = 7;
    to_neg();
    check("store_ret_tags", {ic_tag, dc_tag}, 0);
    check("store_counts", {ic_outstanding, dc_outstanding}, 0);
    to_next(); idle();

    // Randomized traffic: a busy-return phase then a slow-return phase that
    // drives both ports into their caps.
    for (int c = 0; c < 1600; c++) begin
      int ret_pct = (c < 800) ? 45 : 12;
      reset        = ($urandom_range(399, 0) != 0);
      ic_command   = ($urandom_range(99, 0) < 60) ? 2'd1 : 2'd0;
      dc_command   = 2'($urandom_range(2, 0));
      ic_addr      = {$urandom, $urandom};
      dc_addr      = {$urandom, $urandom};
      dc_wr_data   = {$urandom, $urandom};
      mem_data_in  = {$urandom, $urandom};
      mem_response = ($urandom_range(99, 0) < 75) ? 4'(pick_free()) : 4'd0;
      if ($urandom_range(99, 0) < ret_pct)      mem_tag = 4'(pick_pending());
      else if ($urandom_range(99, 0) < 8)       mem_tag = 4'($urandom_range(15, 0));
      else                                      mem_tag = 4'd0;
      to_next();
    end
    reset = 1'b1; idle();
    to_next();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single processor-to-memory bus between the instruction-cache controller (port I) and the data-cache controller (port D).
- Forwards one request per cycle to memory and routes the memory's same-cycle response back to the granted port.
- Keeps a 16-entry tag ownership table so returning load data (tagged) reaches the port that issued the load.
- D has priority; a starvation counter guarantees I forward progress; a per-port outstanding cap throttles each cache.

Parameters:
STARVE_LIMIT, 4, consecutive cycles I may be denied a grant before it is forced to win.
MAX_OUT_I, 8, maximum outstanding I loads (1..15).
MAX_OUT_D, 8, maximum outstanding D loads (1..15).

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ic_command  in  2  I request: BUS_NONE=0, BUS_LOAD=1 (BUS_STORE is never issued by I)
ic_addr  in  64  I request address
ic_response  out  4  memory response forwarded to I; 0 = not accepted
ic_tag  out  4  returning tag for I; 0 = none
ic_data  out  64  returning data (mem_data_in pass-through)
dc_command  in  2  D request: NONE=0, LOAD=1, STORE=2
dc_addr  in  64  D request address
dc_wr_data  in  64  D store data
dc_response  out  4  memory response forwarded to D
dc_tag  out  4  returning tag for D
dc_data  out  64  returning data (mem_data_in pass-through)
mem_command  out  2  command to memory
mem_addr  out  64  address to memory
mem_data  out  64  store data to memory (dc_wr_data when D granted, else 0)
mem_response  in  4  memory acceptance tag; 0 = refused
mem_tag  in  4  tag of data returning this cycle; 0 = none
mem_data_in  in  64  returning data
ic_outstanding  out  4  current I outstanding-load count
dc_outstanding  out  4  current D outstanding-load count

Behaviour:
- State: starve_cnt (0..STARVE_LIMIT), owner[15:1] (0=I, 1=D), pend[15:1], ic_out_cnt, dc_out_cnt.
- While reset=0, all state clears to 0 immediately. Combinational outputs are also forced: mem_command=NONE, mem_addr=0, mem_data=0, all responses and tags=0.
- Eligibility:
  - I is eligible when ic_command==LOAD and ic_out_cnt<MAX_OUT_I.
  - D is eligible when dc_command==STORE, or when dc_command==LOAD and dc_out_cnt<MAX_OUT_D.
- Grant is combinational in the same cycle:
  - If I is eligible and starve_cnt==STARVE_LIMIT, grant I.
  - Otherwise, if D is eligible, grant D.
  - Otherwise, if I is eligible, grant I.
  - Otherwise, no grant: mem_command=NONE.
- Granted port's command and address drive the mem_* outputs. mem_response goes to the granted port's response output. The other port's response is 0.
- Accepted = grant present and mem_response!=0.
- Starvation counter:
  - ic_command!=LOAD, or I granted and accepted: next starve_cnt=0.
  - I eligible but not granted: increment, saturating at STARVE_LIMIT.
  - I granted but refused: hold.
  - I ineligible only because of its outstanding cap: hold.
- Accepted LOAD: owner[mem_response]<=grantee, pend[mem_response]<=1, grantee's outstanding count +1. Accepted STORE records nothing.
- Return: when mem_tag!=0 and pend[mem_tag]==1, drive mem_tag on the owner's tag output (other tag output 0), clear pend[mem_tag], and decrement the owner's count. mem_tag!=0 with pend clear is ignored (both tag outputs 0).
- Data outputs always pass mem_data_in through.
- Same cycle, same tag, return and new acceptance: the return uses the old owner; afterwards pend=1 with the new owner.
- Same cycle, same port, +1 and -1: count unchanged.
- Counters never exceed their cap, because eligibility masks requests at the cap.
- Reset asserted mid-operation discards all pending entries. Tags that return later are ignored.

Test Plan:
- Reset low for 2 cycles, then high, both ports idle -> mem_command=0; responses, tags, counters, starve_cnt all 0.
- D LOAD 0x100 with I LOAD 0x200 in the same cycle, mem_response=3 -> D granted, dc_response=3, ic_response=0; later mem_tag=3 -> dc_tag=3, ic_tag=0, dc_outstanding 1->0.
- D issues continuous STOREs while I holds LOAD 0x40 (STARVE_LIMIT=4), memory always accepts -> I granted on cycle 5, ic_response!=0, starve_cnt back to 0.
- I issues 8 accepted loads with no returns (MAX_OUT_I=8) -> ic_outstanding=8, next I LOAD not forwarded (mem_command=0 if D idle); one I tag returns -> ic_outstanding=7 and the next I load issues.
- mem_tag=5 returns for an I-owned entry while D's new load is accepted with mem_response=5 -> ic_tag=5 this cycle; next mem_tag=5 -> dc_tag=5.
- D STORE accepted with tag 7, later mem_tag=7 -> both tag outputs 0, counters unchanged.
